// File: rtl/refill_write_buffer.sv
// Multi-entry write buffer between cache refill logic and the data/tag RAMs.
// It is a circular FIFO with a first-word-fall-through head, optional in-place coalescing, and lookup forwarding.
module refill_write_buffer #(
  parameter int DATA_W   = 128,
  parameter int INDEX_W  = 8,
  parameter int TAG_W    = 20,
  parameter int WAY_W    = 1,
  parameter int DEPTH    = 4,
  parameter int COALESCE = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [INDEX_W-1:0] in_index,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [WAY_W-1:0]   in_way,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [INDEX_W-1:0] out_index,
  output logic [TAG_W-1:0]   out_tag,
  output logic [WAY_W-1:0]   out_way,
  input  logic [INDEX_W-1:0] lk_index,
  input  logic [TAG_W-1:0]   lk_tag,
  output logic               lk_hit,
  output logic [DATA_W-1:0]  lk_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0]  data_q  [DEPTH];
  logic [INDEX_W-1:0] index_q [DEPTH];
  logic [TAG_W-1:0]   tag_q   [DEPTH];
  logic [WAY_W-1:0]   way_q   [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [DEPTH-1:0] ent_valid, lk_match, wr_match;
  logic             pop, push, new_push, coal, co_hit;
  logic [PTR_W-1:0] co_slot, slot;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;

  // Entry validity comes from its distance behind the read pointer.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      logic [PTR_W-1:0] off;
      assign off           = PTR_W'(gi) - rd_ptr_q;
      assign ent_valid[gi] = CNT_W'(off) < count_q;
      assign lk_match[gi]  = ent_valid[gi] && (index_q[gi] == lk_index) && (tag_q[gi] == lk_tag);
      assign wr_match[gi]  = ent_valid[gi] && !(pop && (off == '0)) &&
                             (index_q[gi] == in_index) && (tag_q[gi] == in_tag) &&
                             (way_q[gi] == in_way);
    end
  endgenerate

  // Walk oldest to youngest so the last match found is the youngest.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    co_hit  = 1'b0;
    co_slot = '0;
    slot    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr_q + PTR_W'(k);
      if (lk_match[slot]) begin
        lk_hit  = 1'b1;
        lk_data = data_q[slot];
      end
      if (wr_match[slot]) begin
        co_hit  = 1'b1;
        co_slot = slot;
      end
    end
  end

  assign coal     = (COALESCE != 0) && co_hit;
  assign in_ready = coal || (count_q < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign new_push = push && !coal;

  always_comb begin
    count_d  = count_q;
    if (new_push && !pop)
      count_d = count_q + CNT_W'(1);
    else if (!new_push && pop)
      count_d = count_q - CNT_W'(1);
    wr_ptr_d = new_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= '0;
        index_q[i] <= '0;
        tag_q[i]   <= '0;
        way_q[i]   <= '0;
      end
    end else begin
      if (push && coal)
        data_q[co_slot] <= in_data;
      if (new_push) begin
        data_q[wr_ptr_q]  <= in_data;
        index_q[wr_ptr_q] <= in_index;
        tag_q[wr_ptr_q]   <= in_tag;
        way_q[wr_ptr_q]   <= in_way;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign out_data  = out_valid ? data_q[rd_ptr_q]  : '0;
  assign out_index = out_valid ? index_q[rd_ptr_q] : '0;
  assign out_tag   = out_valid ? tag_q[rd_ptr_q]   : '0;
  assign out_way   = out_valid ? way_q[rd_ptr_q]   : '0;
  assign count     = count_q;

endmodule
